mapper_context_seq: RTL

- Sequences save/restore of the user mapper context (MAP A/X/Y/Z registers) around hypervisor entry and exit.
- On a save request it reads the four user map registers through the mapper's register-readout mux into a shadow file.
- On a restore request it writes the shadow file back through the mapper's hypervisor register-load port, only while no MAP instruction is in progress.
- Hypervisor software can read and edit the shadow file between save and restore; this block arbitrates that access.

---
 rtl/mapper_pkg.sv | 17 +
 rtl/mapper_context_seq_if.sv | 36 +++
 rtl/mapper_shadow_rf.sv | 30 +++
 rtl/mapper_context_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared encodings for the mapper context save/restore sequencer.
// Register indices double as the rd_sel / write_sel encoding used by the mapper.
package mapper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RWAIT   = 2'd2,
    ST_RESTORE = 2'd3
  } map_state_t;

  localparam logic [1:0] REG_A = 2'd3;
  localparam logic [1:0] REG_X = 2'd2;
  localparam logic [1:0] REG_Y = 2'd1;
  localparam logic [1:0] REG_Z = 2'd0;

endpackage

// File: rtl/mapper_context_seq_if.sv
// Bundle of the mapper-side and hypervisor-side signals of the context sequencer.
// slave = sequencer view, master = mapper/hypervisor view.
interface mapper_context_seq_if;

  logic       phi2;
  logic       map_busy;
  logic       save_req;
  logic       restore_req;
  logic [1:0] rd_sel;
  logic [7:0] map_reg_data;
  logic       load_user_reg;
  logic [1:0] write_sel;
  logic [7:0] write_data;
  logic [1:0] sh_sel;
  logic       sh_wr;
  logic [7:0] sh_wdata;
  logic [7:0] sh_rdata;
  logic       sh_ready;
  logic       busy;
  logic       done;

  modport slave (
    input  phi2, map_busy, save_req, restore_req, map_reg_data,
           sh_sel, sh_wr, sh_wdata,
    output rd_sel, load_user_reg, write_sel, write_data,
           sh_rdata, sh_ready, busy, done
  );

  modport master (
    output phi2, map_busy, save_req, restore_req, map_reg_data,
           sh_sel, sh_wr, sh_wdata,
    input  rd_sel, load_user_reg, write_sel, write_data,
           sh_rdata, sh_ready, busy, done
  );

endinterface

// File: rtl/mapper_shadow_rf.sv
// 4x8 shadow register file: one synchronous write port, two asynchronous read ports.
// Cleared by reset so a fresh hypervisor entry never restores stale contents.
module mapper_shadow_rf (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] wsel,
  input  logic [7:0] wdata,
  input  logic [1:0] rsel_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] rsel_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[wsel] <= wdata;
    end
  end

  assign rdata_a = mem[rsel_a];
  assign rdata_b = mem[rsel_b];

endmodule

// File: rtl/mapper_context_seq.sv
// Saves the user MAP A/X/Y/Z registers into a shadow file on hypervisor entry and
// writes them back on exit, one register per step, never while a MAP is in flight.
module mapper_context_seq
  import mapper_pkg::*;
#(
  parameter bit STEP_ON_PHI2 = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  mapper_context_seq_if.slave bus
);

  map_state_t state, state_next;
  logic [1:0] idx, idx_next;
  logic       done_flag, done_next;
  logic       step;
  logic       sh_ready;
  logic       save_we;
  logic       rf_we;
  logic [1:0] rf_wsel;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata_a;
  logic [7:0] rf_rdata_b;

  assign step     = STEP_ON_PHI2 ? bus.phi2 : 1'b1;
  assign sh_ready = (state == ST_IDLE) || (state == ST_RWAIT);

  // The save path and hypervisor writes never collide: sh_ready is low during SAVE.
  assign rf_we    = save_we | (bus.sh_wr & sh_ready);
  assign rf_wsel  = save_we ? idx : bus.sh_sel;
  assign rf_wdata = save_we ? bus.map_reg_data : bus.sh_wdata;

  mapper_shadow_rf u_shadow (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .wsel    (rf_wsel),
    .wdata   (rf_wdata),
    .rsel_a  (bus.sh_sel),
    .rdata_a (rf_rdata_a),
    .rsel_b  (idx),
    .rdata_b (rf_rdata_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= REG_A;
      done_flag <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      done_flag <= done_next;
    end
  end

  always_comb begin
    state_next        = state;
    idx_next          = idx;
    done_next         = 1'b0;
    save_we           = 1'b0;
    bus.rd_sel        = 2'd0;
    bus.load_user_reg = 1'b0;
    bus.write_sel     = 2'd0;
    bus.write_data    = 8'h00;

    case (state)
      ST_IDLE: begin
        // Save has priority; a simultaneous restore request is dropped.
        if (bus.save_req) begin
          state_next = ST_SAVE;
          idx_next   = REG_A;
        end else if (bus.restore_req) begin
          state_next = ST_RWAIT;
        end
      end

      ST_SAVE: begin
        bus.rd_sel = idx;
        if (step) begin
          save_we = 1'b1;
          if (idx == REG_Z) begin
            state_next = ST_IDLE;
            idx_next   = REG_A;
            done_next  = 1'b1;
          end else begin
            idx_next = idx - 2'd1;
          end
        end
      end

      ST_RWAIT: begin
        if (step && !bus.map_busy) begin
          state_next = ST_RESTORE;
          idx_next   = REG_A;
        end
      end

      ST_RESTORE: begin
        bus.write_sel  = idx;
        bus.write_data = rf_rdata_b;
        // A blocked step simply holds idx, so nothing is repeated or skipped.
        if (step && !bus.map_busy) begin
          bus.load_user_reg = 1'b1;
          if (idx == REG_Z) begin
            state_next = ST_IDLE;
            idx_next   = REG_A;
            done_next  = 1'b1;
          end else begin
            idx_next = idx - 2'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        idx_next   = REG_A;
      end
    endcase
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = done_flag;
  assign bus.sh_ready = sh_ready;
  assign bus.sh_rdata = rf_rdata_a;

endmodule
